cache_writeback_buffer: RTL and testbench
=========================================

// Module: cache_writeback_buffer
// PURPOSE
//  Victim/write-back buffer between a cache core's downstream port and memory (or next cache level).
//  Absorbs dirty-line write-backs into a small FIFO so the miss fill read is issued to memory ahead of the eviction.
//  Read requests that match a buffered line are served from the buffer.
//  Buffered lines drain to memory when the memory port is otherwise idle.
// PARAMETERS
//  s_offset  5    byte-offset bits per line; line address = addr[31:s_offset]
//  s_line    256  line width in bits
//  s_depth   2    log2 of entry count
//  depth     4    2**s_depth entries (derived; do not override)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       synchronous, active-high reset
//  up_read      in   1       line read from cache core; held until up_resp
//  up_write     in   1       dirty line write-back from cache core; held until up_resp
//  up_address   in   32      line address of up_read/up_write
//  up_wdata     in   s_line  write-back line data
//  up_resp      out  1       one-cycle completion pulse, registered
//  up_rdata     out  s_line  read data, valid while up_resp=1, registered
//  mem_read     out  1       memory line read, held until mem_resp
//  mem_write    out  1       memory line write (drain), held until mem_resp
//  mem_address  out  32      memory address, {line addr, s_offset'b0}
//  mem_wdata    out  s_line  drain data, stable during mem_write
//  mem_resp     in   1       memory completion, one cycle
//  mem_rdata    in   s_line  memory read data, valid with mem_resp
//  wb_empty     out  1       1 when no valid entries and no memory transaction in flight
// BEHAVIOUR
//  Reset
//   - All entries invalid; head = tail = count = 0; both FSMs idle.
//   - up_resp = mem_read = mem_write = 0; up_rdata = mem_wdata = 0; mem_address = 0; wb_empty = 1.
//   - Reset mid-transaction abandons it. Buffered data is lost; no response is issued.
//  Storage
//   - FIFO of depth entries: {valid, line addr, data}.
//   - Pointers wrap modulo depth; count is s_depth+1 bits.
//   - full = (count == depth).
//  Upstream FSM: UP_IDLE, UP_RESP
//   - In UP_RESP, up_resp=1 for exactly one cycle, then UP_IDLE.
//   - Requests in UP_RESP are ignored: the core still holds the old request during that cycle.
//  Write, sampled in UP_IDLE
//   - Coalesce: if a valid entry has the same line address, overwrite its data and go to UP_RESP.
//     Response latency: 1 cycle.
//   - Exception: a matching entry that is the head while a drain is in flight is not overwritten.
//     The write allocates a new entry instead.
//   - Otherwise, if not full: enqueue at tail, tail++, count++, go to UP_RESP.
//   - If full: stall (no state change) until a drain pop frees an entry.
//     Pop and enqueue in the same cycle are legal; count is unchanged.
//  Read, sampled in UP_IDLE
//   - Buffer hit: up_rdata <= youngest matching entry's data, then UP_RESP. Latency 1 cycle.
//     A hit on the entry currently draining is legal.
//   - Miss: raise a memory read request.
//  Memory FSM: M_IDLE, M_READ, M_WRITE
//   - M_IDLE: a pending miss read has priority -> M_READ (mem_read=1 from the next cycle).
//     Else, if count != 0 -> M_WRITE on the head (mem_write=1, address/data from head).
//   - M_READ: on mem_resp, up_rdata <= mem_rdata, upstream -> UP_RESP, memory -> M_IDLE.
//   - M_WRITE: on mem_resp, invalidate head, head++, count--, -> M_IDLE.
//   - A read arriving during M_WRITE waits for mem_resp, then issues next cycle.
//   - mem_read and mem_write are never both 1.
//   - Outputs are held constant until mem_resp.
//  Ordering
//   - Drains leave in FIFO order.
//   - Read hits always return the youngest data, so memory is never read stale relative to the buffer.
// TESTING
//  1. Reset, then write A=0x1000 (data D1): up_resp at cycle 1, count=1.
//     Next idle cycle mem_write to 0x1000 with D1; mem_resp -> wb_empty=1.
//  2. Write 0x2000, then read 0x3000 while mem is busy with an external stall.
//     The read issues first (mem_read, 0x3000); the drain of 0x2000 follows; up_rdata equals mem_rdata.
//  3. Write 0x4000 D1, then read 0x4000 before drain: up_resp 1 cycle later, up_rdata=D1, no mem_read.
//  4. Fill 4 entries with mem_resp held low, then a 5th write stalls.
//     Release one mem_resp: the 5th write is accepted the next cycle and the wrapped tail equals 0.
//  5. Write 0x5000 D1, then 0x5000 D2 before drain: count stays 1 and the drain writes D2.
//     Same while 0x5000 is draining: a new entry is allocated, mem_wdata stays D1, and a read returns D2.
//  6. Assert rst during M_WRITE with 3 entries: next cycle all outputs are 0, wb_empty=1, and no up_resp.

Source files
------------

// File: rtl/cache_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cache_writeback_buffer
// Brief    : Victim/write-back FIFO between a cache core and memory. Misses
//            overtake buffered evictions; read hits are served from the buffer.
// Revision : 1.0 - initial release
// ============================================================================
module cache_writeback_buffer #(
    parameter int S_OFFSET = 5,
    parameter int S_LINE   = 256,
    parameter int S_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_read,
    input  logic              up_write,
    input  logic [31:0]       up_address,
    input  logic [S_LINE-1:0] up_wdata,
    output logic              up_resp,
    output logic [S_LINE-1:0] up_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [S_LINE-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [S_LINE-1:0] mem_rdata,
    output logic              wb_empty
);
    localparam int               C_DEPTH = 2 ** S_DEPTH;
    localparam int               C_TAG_W = 32 - S_OFFSET;
    localparam logic [S_DEPTH:0] C_FULL  = (S_DEPTH + 1)'(C_DEPTH);

    typedef enum logic [0:0] {UP_IDLE = 1'b0, UP_RESP = 1'b1} up_state_t;
    typedef enum logic [1:0] {M_IDLE = 2'd0, M_READ = 2'd1, M_WRITE = 2'd2} mem_state_t;

    up_state_t          r_up_state, w_up_next;
    mem_state_t         r_m_state,  w_m_next;

    logic [C_DEPTH-1:0] r_valid;
    logic [C_TAG_W-1:0] r_tag  [C_DEPTH];
    logic [S_LINE-1:0]  r_data [C_DEPTH];
    logic [S_DEPTH-1:0] r_head, r_tail;
    logic [S_DEPTH:0]   r_count;
    logic               r_rd_pend;

    logic [C_TAG_W-1:0] w_up_tag;
    logic [S_DEPTH-1:0] w_scan, w_rd_idx, w_wr_idx;
    logic               w_rd_hit, w_wr_match;
    logic               w_up_idle, w_wr_req, w_rd_req;
    logic               w_coalesce, w_enq, w_pop, w_hit_resp, w_miss, w_rd_done;
    logic               w_full;
    logic               w_unused_ok;

    assign w_up_tag    = up_address[31:S_OFFSET];
    assign w_unused_ok = &{1'b0, up_address[S_OFFSET-1:0]};

    // Scan oldest to youngest so the last match wins. The head being drained
    // is frozen: writes to it must open a fresh entry instead.
    always_comb begin
        w_rd_hit   = 1'b0;
        w_rd_idx   = r_head;
        w_wr_match = 1'b0;
        w_wr_idx   = r_head;
        w_scan     = r_head;
        for (int i = 0; i < C_DEPTH; i++) begin
            w_scan = r_head + S_DEPTH'(i);
            if (r_valid[w_scan] && (r_tag[w_scan] == w_up_tag)) begin
                w_rd_hit = 1'b1;
                w_rd_idx = w_scan;
                if (!((w_scan == r_head) && (r_m_state == M_WRITE))) begin
                    w_wr_match = 1'b1;
                    w_wr_idx   = w_scan;
                end
            end
        end
    end

    assign w_full     = (r_count == C_FULL);
    assign w_up_idle  = (r_up_state == UP_IDLE);
    assign w_wr_req   = w_up_idle && up_write;
    assign w_rd_req   = w_up_idle && up_read && !up_write;
    assign w_pop      = (r_m_state == M_WRITE) && mem_resp;
    assign w_coalesce = w_wr_req && w_wr_match;
    assign w_enq      = w_wr_req && !w_wr_match && (!w_full || w_pop);
    assign w_hit_resp = w_rd_req && w_rd_hit;
    assign w_miss     = w_rd_req && !w_rd_hit && !r_rd_pend && (r_m_state != M_READ);
    assign w_rd_done  = (r_m_state == M_READ) && mem_resp;

    always_comb begin
        w_up_next = r_up_state;
        case (r_up_state)
            UP_IDLE: if (w_coalesce || w_enq || w_hit_resp || w_rd_done) w_up_next = UP_RESP;
            UP_RESP: w_up_next = UP_IDLE;
            default: w_up_next = UP_IDLE;
        endcase
    end

    // A miss always goes ahead of queued evictions.
    always_comb begin
        w_m_next = r_m_state;
        case (r_m_state)
            M_IDLE: begin
                if (r_rd_pend || w_miss)  w_m_next = M_READ;
                else if (r_count != '0)   w_m_next = M_WRITE;
            end
            M_READ:  if (mem_resp) w_m_next = M_IDLE;
            M_WRITE: if (mem_resp) w_m_next = M_IDLE;
            default: w_m_next = M_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_up_state  <= UP_IDLE;
            r_m_state   <= M_IDLE;
            r_valid     <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_rd_pend   <= 1'b0;
            up_rdata    <= '0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            r_up_state <= w_up_next;
            r_m_state  <= w_m_next;

            if (r_m_state == M_IDLE) r_rd_pend <= 1'b0;
            else if (w_miss)         r_rd_pend <= 1'b1;

            // On a full-buffer pop+enqueue head == tail, so the enqueue's set wins.
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + S_DEPTH'(1);
            end
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + S_DEPTH'(1);
            end
            r_count <= r_count + (S_DEPTH + 1)'(w_enq) - (S_DEPTH + 1)'(w_pop);

            if (w_hit_resp)     up_rdata <= r_data[w_rd_idx];
            else if (w_rd_done) up_rdata <= mem_rdata;

            if ((r_m_state == M_IDLE) && (w_m_next == M_READ)) begin
                mem_address <= {w_up_tag, {S_OFFSET{1'b0}}};
            end else if ((r_m_state == M_IDLE) && (w_m_next == M_WRITE)) begin
                mem_address <= {r_tag[r_head], {S_OFFSET{1'b0}}};
                // Forward a same-cycle coalesce into the head being launched.
                mem_wdata   <= (w_coalesce && (w_wr_idx == r_head)) ? up_wdata : r_data[r_head];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_coalesce) r_data[w_wr_idx] <= up_wdata;
        if (w_enq) begin
            r_tag[r_tail]  <= w_up_tag;
            r_data[r_tail] <= up_wdata;
        end
    end

    assign up_resp   = (r_up_state == UP_RESP);
    assign mem_read  = (r_m_state == M_READ);
    assign mem_write = (r_m_state == M_WRITE);
    assign wb_empty  = (r_count == '0) && (r_m_state == M_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cache_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_writeback_buffer
// Brief    : Directed and randomized bench; reference is "latest data written
//            per line" plus a scripted memory responder with a transaction log.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cache_writeback_buffer;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          up_read, up_write;
    logic [31:0]   up_address;
    logic [LW-1:0] up_wdata;
    logic          up_resp;
    logic [LW-1:0] up_rdata;
    logic          mem_read, mem_write;
    logic [31:0]   mem_address;
    logic [LW-1:0] mem_wdata;
    logic          mem_resp = 1'b0;
    logic [LW-1:0] mem_rdata = '0;
    logic          wb_empty;

    cache_writeback_buffer dut (
        .clk(clk), .rst(rst),
        .up_read(up_read), .up_write(up_write), .up_address(up_address),
        .up_wdata(up_wdata), .up_resp(up_resp), .up_rdata(up_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .wb_empty(wb_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            wr;
        logic [31:0]   addr;
        logic [LW-1:0] data;
    } txn_t;

    txn_t          mlog[$];
    logic [LW-1:0] mem_arr     [logic [31:0]];
    logic [LW-1:0] last_written[logic [31:0]];
    int            mem_delay = 1;
    int            resp_limit = 1 << 30;
    int            resp_count = 0;
    int            wait_cnt   = 0;
    int            proto_err  = 0;
    int            rd_cycles  = 0;
    logic [31:0]   cur_addr;
    logic [LW-1:0] cur_wdata;
    logic          cur_rd;
    int            n_checks = 0;
    int            n_pass   = 0;

    function automatic logic [LW-1:0] init_val(input logic [31:0] a);
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Memory model: answers after mem_delay cycles unless throttled by resp_limit.
    always @(posedge clk) begin
        txn_t t;
        #2;
        if (mem_resp) begin
            mem_resp = 1'b0;
        end else if (rst || !(mem_read || mem_write)) begin
            wait_cnt = 0;
        end else begin
            if (mem_read && mem_write) proto_err++;
            if (mem_read) rd_cycles++;
            if (wait_cnt == 0) begin
                cur_addr = mem_address; cur_wdata = mem_wdata; cur_rd = mem_read;
            end else if (mem_address !== cur_addr || mem_read !== cur_rd ||
                         (mem_write && mem_wdata !== cur_wdata)) begin
                proto_err++;
            end
            if (wait_cnt >= mem_delay && resp_count < resp_limit) begin
                t.wr = mem_write; t.addr = mem_address;
                if (mem_write) begin
                    t.data = mem_wdata;
                    mem_arr[mem_address] = mem_wdata;
                end else begin
                    t.data = mem_arr.exists(mem_address) ? mem_arr[mem_address] : init_val(mem_address);
                end
                mem_rdata = t.data;
                mem_resp  = 1'b1;
                mlog.push_back(t);
                resp_count++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [LW-1:0] d, output int lat);
        up_write = 1'b1; up_address = a; up_wdata = d; lat = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (up_resp) begin lat = i; break; end
        end
        up_write = 1'b0;
        if (lat > 0) last_written[a] = d;
        tick();
    endtask

    task automatic do_read(input logic [31:0] a, output logic [LW-1:0] d, output int lat);
        up_read = 1'b1; up_address = a; lat = -1; d = 'x;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (up_resp) begin lat = i; d = up_rdata; break; end
        end
        up_read = 1'b0;
        tick();
    endtask

    task automatic wait_empty(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (wb_empty) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    function automatic logic [LW-1:0] expect_line(input logic [31:0] a);
        return last_written.exists(a) ? last_written[a] : init_val(a);
    endfunction

    task automatic test_reset();
        rst = 1'b1; up_read = 1'b0; up_write = 1'b0; up_address = '0; up_wdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_checks++; if (up_resp !== 1'b0) $display("FAIL reset_up_resp got %b want 0", up_resp); else n_pass++;
        n_checks++; if (mem_read !== 1'b0) $display("FAIL reset_mem_read got %b want 0", mem_read); else n_pass++;
        n_checks++; if (mem_write !== 1'b0) $display("FAIL reset_mem_write got %b want 0", mem_write); else n_pass++;
        n_checks++; if (up_rdata !== '0) $display("FAIL reset_up_rdata got %h want 0", up_rdata); else n_pass++;
        n_checks++; if (mem_wdata !== '0) $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); else n_pass++;
        n_checks++; if (mem_address !== '0) $display("FAIL reset_mem_address got %h want 0", mem_address); else n_pass++;
        n_checks++; if (wb_empty !== 1'b1) $display("FAIL reset_wb_empty got %b want 1", wb_empty); else n_pass++;
    endtask

    task automatic test_single_write();
        logic [LW-1:0] d1 = rand_line();
        int lat, n0;
        bit ok;
        n0 = mlog.size();
        do_write(32'h1000, d1, lat);
        n_checks++; if (lat !== 1) $display("FAIL t1_write_latency got %0d want 1", lat); else n_pass++;
        n_checks++; if (wb_empty !== 1'b0) $display("FAIL t1_not_empty got %b want 0", wb_empty); else n_pass++;
        wait_empty(ok);
        n_checks++; if (!ok) $display("FAIL t1_drain_timeout got busy want wb_empty=1"); else n_pass++;
        n_checks++;
        if (mlog.size() != n0 + 1 || !mlog[n0].wr || mlog[n0].addr !== 32'h1000 || mlog[n0].data !== d1)
            $display("FAIL t1_drain_txn got %0d txns want 1 write to 00001000", mlog.size() - n0);
        else n_pass++;
    endtask

    task automatic test_read_priority();
        logic [31:0]   ea [3];
        bit            ew [3];
        logic [LW-1:0] rd;
        int lat, n0;
        bit ok;
        ea = '{32'h1800, 32'h3000, 32'h2000};
        ew = '{1'b1, 1'b0, 1'b1};
        n0 = mlog.size();
        mem_delay = 8;
        do_write(32'h1800, rand_line(), lat);
        do_write(32'h2000, rand_line(), lat);
        do_read(32'h3000, rd, lat);
        mem_delay = 1;
        n_checks++; if (rd !== expect_line(32'h3000)) $display("FAIL t2_miss_data got %h want %h", rd, expect_line(32'h3000)); else n_pass++;
        wait_empty(ok);
        n_checks++; if (!ok || mlog.size() != n0 + 3) $display("FAIL t2_txn_count got %0d want 3", mlog.size() - n0); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            if (mlog.size() > n0 + i) begin
                n_checks++;
                if (mlog[n0+i].wr !== ew[i] || mlog[n0+i].addr !== ea[i])
                    $display("FAIL t2_order[%0d] got wr=%b addr=%h want wr=%b addr=%h", i, mlog[n0+i].wr, mlog[n0+i].addr, ew[i], ea[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_read_hit();
        logic [LW-1:0] d1 = rand_line();
        logic [LW-1:0] rd;
        int lat, rc0;
        bit ok;
        resp_limit = resp_count;
        do_write(32'h4000, d1, lat);
        rc0 = rd_cycles;
        do_read(32'h4000, rd, lat);
        n_checks++; if (lat !== 1) $display("FAIL t3_hit_latency got %0d want 1", lat); else n_pass++;
        n_checks++; if (rd !== d1) $display("FAIL t3_hit_data got %h want %h", rd, d1); else n_pass++;
        n_checks++; if (rd_cycles !== rc0) $display("FAIL t3_no_mem_read got %0d read cycles want 0", rd_cycles - rc0); else n_pass++;
        resp_limit = 1 << 30;
        wait_empty(ok);
        n_checks++; if (!ok) $display("FAIL t3_drain_timeout got busy want wb_empty=1"); else n_pass++;
    endtask

    task automatic test_full_stall();
        logic [LW-1:0] d [5];
        int lat, n0, early;
        bit ok;
        n0 = mlog.size();
        resp_limit = resp_count;
        for (int i = 0; i < 5; i++) d[i] = rand_line();
        for (int i = 0; i < 4; i++) begin
            do_write(32'h7000 + 32'(i * 32), d[i], lat);
            n_checks++; if (lat !== 1) $display("FAIL t4_fill_latency[%0d] got %0d want 1", i, lat); else n_pass++;
        end
        up_write = 1'b1; up_address = 32'h7080; up_wdata = d[4];
        early = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (up_resp) early++; end
        n_checks++; if (early != 0) $display("FAIL t4_full_stall got %0d responses want 0", early); else n_pass++;
        resp_limit = resp_count + 1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin tick(); if (up_resp) begin lat = i; break; end end
        up_write = 1'b0;
        if (lat > 0) last_written[32'h7080] = d[4];
        n_checks++; if (lat < 1 || lat > 4) $display("FAIL t4_release_accept got %0d cycles want 1..4", lat); else n_pass++;
        tick();
        resp_limit = 1 << 30;
        wait_empty(ok);
        n_checks++; if (!ok || mlog.size() != n0 + 5) $display("FAIL t4_txn_count got %0d want 5", mlog.size() - n0); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (mlog.size() > n0 + i) begin
                n_checks++;
                if (!mlog[n0+i].wr || mlog[n0+i].addr !== 32'h7000 + 32'(i * 32) || mlog[n0+i].data !== d[i])
                    $display("FAIL t4_drain_order[%0d] got addr=%h want addr=%h", i, mlog[n0+i].addr, 32'h7000 + 32'(i * 32));
                else n_pass++;
            end
        end
    endtask

    task automatic test_coalesce();
        logic [LW-1:0] dx = rand_line();
        logic [LW-1:0] d1 = rand_line();
        logic [LW-1:0] d2 = rand_line();
        logic [LW-1:0] d3 = rand_line();
        logic [LW-1:0] rd;
        int lat, n0;
        bit ok, seen;
        n0 = mlog.size();
        resp_limit = resp_count;
        do_write(32'h5800, dx, lat);
        do_write(32'h5000, d1, lat);
        do_write(32'h5000, d2, lat);
        n_checks++; if (lat !== 1) $display("FAIL t5_coalesce_latency got %0d want 1", lat); else n_pass++;
        resp_limit = resp_count + 1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mem_write && mem_address === 32'h5000) begin seen = 1'b1; break; end
            tick();
        end
        n_checks++; if (!seen || mem_wdata !== d2) $display("FAIL t5_drain_data got %h want %h", mem_wdata, d2); else n_pass++;
        do_write(32'h5000, d3, lat);
        n_checks++; if (lat !== 1) $display("FAIL t5_alloc_latency got %0d want 1", lat); else n_pass++;
        n_checks++; if (mem_wdata !== d2) $display("FAIL t5_drain_stable got %h want %h", mem_wdata, d2); else n_pass++;
        do_read(32'h5000, rd, lat);
        n_checks++; if (rd !== d3) $display("FAIL t5_youngest_read got %h want %h", rd, d3); else n_pass++;
        resp_limit = 1 << 30;
        wait_empty(ok);
        n_checks++;
        if (!ok || mlog.size() != n0 + 3 || mlog[n0].data !== dx || mlog[n0+1].data !== d2 ||
            mlog[n0+2].addr !== 32'h5000 || mlog[n0+2].data !== d3)
            $display("FAIL t5_drain_log got %0d txns want 3 (5800,5000:D2,5000:D3)", mlog.size() - n0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, bad;
        bit ok;
        resp_limit = resp_count;
        for (int i = 0; i < 3; i++) do_write(32'h6000 + 32'(i * 32), rand_line(), lat);
        n_checks++; if (mem_write !== 1'b1) $display("FAIL t6_in_write got %b want 1", mem_write); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) $display("FAIL t6_mem_ctrl got rd=%b wr=%b want 0 0", mem_read, mem_write); else n_pass++;
        n_checks++; if (mem_address !== '0) $display("FAIL t6_mem_address got %h want 0", mem_address); else n_pass++;
        n_checks++; if (mem_wdata !== '0) $display("FAIL t6_mem_wdata got %h want 0", mem_wdata); else n_pass++;
        n_checks++; if (up_rdata !== '0) $display("FAIL t6_up_rdata got %h want 0", up_rdata); else n_pass++;
        n_checks++; if (wb_empty !== 1'b1) $display("FAIL t6_wb_empty got %b want 1", wb_empty); else n_pass++;
        resp_limit = 1 << 30;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (up_resp || mem_write || mem_read) bad++;
            tick();
        end
        n_checks++; if (bad != 0) $display("FAIL t6_quiet_after_reset got %0d active cycles want 0", bad); else n_pass++;
        for (int i = 0; i < 3; i++) last_written.delete(32'h6000 + 32'(i * 32));
        wait_empty(ok);
    endtask

    task automatic test_random();
        logic [31:0]   a;
        logic [LW-1:0] d, rd;
        int lat;
        bit ok;
        for (int n = 0; n < 80; n++) begin
            a = 32'h0001_0000 + 32'($urandom_range(0, 5) * 32);
            mem_delay = $urandom_range(0, 4);
            if ($urandom_range(0, 9) < 6) begin
                d = rand_line();
                do_write(a, d, lat);
                n_checks++; if (lat < 1) $display("FAIL rnd_write_timeout[%0d] addr %h got no response", n, a); else n_pass++;
            end else begin
                do_read(a, rd, lat);
                n_checks++;
                if (lat < 1 || rd !== expect_line(a))
                    $display("FAIL rnd_read[%0d] addr %h got %h want %h", n, a, rd, expect_line(a));
                else n_pass++;
            end
        end
        mem_delay = 1;
        wait_empty(ok);
        n_checks++; if (!ok) $display("FAIL rnd_drain_timeout got busy want wb_empty=1"); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            a = 32'h0001_0000 + 32'(k * 32);
            if (last_written.exists(a)) begin
                n_checks++;
                if (!mem_arr.exists(a) || mem_arr[a] !== last_written[a])
                    $display("FAIL rnd_mem_final addr %h got stale want %h", a, last_written[a]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_priority();
        test_read_hit();
        test_full_stall();
        test_coalesce();
        test_reset_mid();
        test_random();
        n_checks++; if (proto_err != 0) $display("FAIL mem_protocol got %0d violations want 0", proto_err); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
